// File: rtl/scan_test_sequencer.sv
// scan_test_sequencer: one scan test = shift pattern in, capture, shift result out, compare to expect
module scan_test_sequencer #(
  parameter int CHAIN_LEN      = 8,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expect_in,
  output logic                 scan_enable,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] result_out
);
  localparam int MAXC = CHAIN_LEN > CAPTURE_CYCLES ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(CAPTURE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d, exp_q, exp_d, res_q, res_d, res_out_q, res_out_d;
  logic pass_q, pass_d;
  logic last, accept;
  assign last = cnt_q == '0;
  assign accept = state_q == IDLE && start && !abort;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pat_q     <= '0;
      exp_q     <= '0;
      res_q     <= '0;
      res_out_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      exp_q     <= exp_d;
      res_q     <= res_d;
      res_out_q <= res_out_d;
      pass_q    <= pass_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (abort && state_q != IDLE) state_d = IDLE;
    else
      case (state_q)
        IDLE:      state_d = accept ? SHIFT_IN : IDLE;
        SHIFT_IN:  state_d = last ? CAPTURE : SHIFT_IN;
        CAPTURE:   state_d = last ? SHIFT_OUT : CAPTURE;
        SHIFT_OUT: state_d = last ? DONE : SHIFT_OUT;
        default:   state_d = IDLE;
      endcase
  end
  always_comb begin
    cnt_d     = last ? '0 : cnt_q - CW'(1);
    pat_d     = pat_q;
    exp_d     = exp_q;
    res_d     = res_q;
    res_out_d = res_out_q;
    pass_d    = pass_q;
    if (accept) begin
      pat_d     = pattern_in;
      exp_d     = expect_in;
      res_d     = '0;
      res_out_d = '0;
      pass_d    = 1'b0;
      cnt_d     = SHIFT_LAST;
    end
    if (state_q == SHIFT_IN) begin
      pat_d = pat_q >> 1;
      if (last) cnt_d = CAP_LAST;
    end
    if (state_q == CAPTURE && last) cnt_d = SHIFT_LAST;
    if (state_q == SHIFT_OUT) begin
      res_d = {scan_out, res_q[CHAIN_LEN-1:1]};
      if (last && !abort) begin
        res_out_d = res_d;
        pass_d    = res_d == exp_q;
      end
    end
  end
  always_comb begin
    scan_enable = state_q == SHIFT_IN || state_q == SHIFT_OUT;
    scan_in     = state_q == SHIFT_IN && pat_q[0];
    busy        = state_q != IDLE;
    done        = state_q == DONE;
    pass        = pass_q;
    result_out  = res_out_q;
  end
endmodule

// File: tb/tb_scan_test_sequencer.sv
// tb_scan_test_sequencer: scoreboard bench driving two sequencers (capture 1 and 3) with chain models
module tb_scan_test_sequencer;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [7:0] pattern_in = 0, expect_in = 0, func_data_in = 0;
  logic se0, si0, so0, busy0, done0, pass0, se1, si1, so1, busy1, done1, pass1;
  logic [7:0] res0, res1, ch0, ch1;
  logic [8:0] sb[$];
  int npass = 0, ntot = 0;
  always #5 clk = ~clk;
  scan_test_sequencer #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern_in(pattern_in),
    .expect_in(expect_in), .scan_enable(se0), .scan_in(si0), .scan_out(so0), .busy(busy0),
    .done(done0), .pass(pass0), .result_out(res0));
  scan_test_sequencer #(.CHAIN_LEN(8), .CAPTURE_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern_in(pattern_in),
    .expect_in(expect_in), .scan_enable(se1), .scan_in(si1), .scan_out(so1), .busy(busy1),
    .done(done1), .pass(pass1), .result_out(res1));
  always_ff @(posedge clk) ch0 <= se0 ? {si0, ch0[7:1]} : func_data_in;
  always_ff @(posedge clk) ch1 <= se1 ? {si1, ch1[7:1]} : func_data_in;
  assign so0 = ch0[0];
  assign so1 = ch1[0];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [7:0] pat, input logic [7:0] exp);
    start = 1;
    pattern_in = pat;
    expect_in = exp;
    tick();
    start = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    tick();
    ntot++; if ({se0, si0, busy0, done0, pass0, res0} !== 13'd0) $display("FAIL reset_outs got %b want 0", {se0, si0, busy0, done0, pass0, res0}); else npass++;
    ntot++; if ({se1, busy1, done1, pass1, res1} !== 12'd0) $display("FAIL reset_outs1 got %b want 0", {se1, busy1, done1, pass1, res1}); else npass++;
    rst_n = 1;
    tick();
  endtask
  task automatic run_test(input bit sel, input logic [7:0] pat, input logic [7:0] exp, input bit extra);
    int cap = sel ? 3 : 1;
    int lat = 17 + cap;
    int ndone = 0, dcyc = 0, nbusy = 0, nlow = 0;
    logic [8:0] e;
    logic se, bz, dn, ps;
    logic [7:0] rs, ch;
    sb.push_back({func_data_in, func_data_in == exp});
    do_start(pat, exp);
    for (int k = 1; k <= lat + 4; k++) begin
      se = sel ? se1 : se0; bz = sel ? busy1 : busy0; dn = sel ? done1 : done0;
      ps = sel ? pass1 : pass0; rs = sel ? res1 : res0; ch = sel ? ch1 : ch0;
      if (extra) start = (k == 3 || k == 17);
      if (k == 9) begin
        ntot++; if (ch !== pat) $display("FAIL chain_loaded got %h want %h", ch, pat); else npass++;
      end
      if (bz) nbusy++;
      if (k < lat && !se) nlow++;
      if (dn) begin
        ndone++;
        dcyc = k;
        if (sb.size() == 0) begin
          ntot++; $display("FAIL unexpected_done at cycle %0d", k);
        end else begin
          e = sb.pop_front();
          ntot++; if (rs !== e[8:1]) $display("FAIL result_out got %h want %h", rs, e[8:1]); else npass++;
          ntot++; if (ps !== e[0]) $display("FAIL pass got %b want %b", ps, e[0]); else npass++;
        end
      end
      tick();
    end
    start = 0;
    ntot++; if (ndone != 1) $display("FAIL done_count got %0d want 1", ndone); else npass++;
    ntot++; if (dcyc != lat) $display("FAIL done_cycle got %0d want %0d", dcyc, lat); else npass++;
    ntot++; if (nbusy != lat) $display("FAIL busy_cycles got %0d want %0d", nbusy, lat); else npass++;
    ntot++; if (nlow != cap) $display("FAIL se_low_cycles got %0d want %0d", nlow, cap); else npass++;
    if (sb.size() != 0) begin
      ntot++; $display("FAIL missing_done got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_abort();
    int nd = 0;
    func_data_in = 8'h3C;
    do_start(8'hA5, 8'h3C);
    repeat (12) tick();
    abort = 1;
    tick();
    abort = 0;
    ntot++; if ({se0, busy0, done0} !== 3'b000) $display("FAIL abort_ctrl got %b want 000", {se0, busy0, done0}); else npass++;
    ntot++; if ({pass0, res0} !== 9'd0) $display("FAIL abort_result got %h want 0", {pass0, res0}); else npass++;
    ntot++; if (busy1 !== 1'b0) $display("FAIL abort_busy1 got %b want 0", busy1); else npass++;
    for (int k = 0; k < 20; k++) begin
      if (done0 || busy0) nd++;
      tick();
    end
    ntot++; if (nd != 0) $display("FAIL abort_no_done got %0d want 0", nd); else npass++;
  endtask
  task automatic test_reset_mid();
    func_data_in = 8'h3C;
    do_start(8'hFF, 8'h00);
    repeat (8) tick();
    rst_n = 0;
    #1;
    ntot++; if ({se0, si0, busy0, done0, pass0, res0} !== 13'd0) $display("FAIL midreset_outs got %b want 0", {se0, si0, busy0, done0, pass0, res0}); else npass++;
    ntot++; if (busy1 !== 1'b0) $display("FAIL midreset_busy1 got %b want 0", busy1); else npass++;
    tick();
    rst_n = 1;
    tick();
    func_data_in = 8'h00;
    run_test(0, 8'hFF, 8'h00, 0);
  endtask
  initial begin
    test_reset();
    func_data_in = 8'h3C;
    run_test(0, 8'hA5, 8'h3C, 0);
    run_test(0, 8'hA5, 8'h3D, 0);
    run_test(0, 8'hA5, 8'h3C, 1);
    test_abort();
    test_reset_mid();
    func_data_in = 8'h81;
    run_test(1, 8'h5A, 8'h81, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/scan_test_sequencer.md
Name: scan_test_sequencer

Overview:
- Sequences one scan test over the 8-bit scan-chain register block.
- Test order: serially load a stimulus pattern, drop scan_enable for a functional capture, then serially unload the captured word and compare it against an expected value.
- Sits between the test/BIST control logic (start/pattern/expect/result) and the scan-chain block (scan_enable, scan_in, scan_out).

Parameters:
- CHAIN_LEN, 8: scan chain length in bits; width of pattern, expect and result; number of shift cycles per phase.
- CAPTURE_CYCLES, 1: cycles with scan_enable low in the capture phase; legal range 1..15.

Ports:
- clk, input, 1: rising-edge clock shared with the scan chain.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request a test; sampled only in IDLE.
- abort, input, 1: cancel a running test; takes priority over every other transition.
- pattern_in, input, CHAIN_LEN: stimulus word, latched when start is accepted.
- expect_in, input, CHAIN_LEN: expected capture word, latched when start is accepted.
- scan_enable, output, 1: drives the chain's scan_enable.
- scan_in, output, 1: serial data into the chain.
- scan_out, input, 1: serial data from the chain (chain bit 0).
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when a test completes (not on abort).
- pass, output, 1: result == expect for the last completed test.
- result_out, output, CHAIN_LEN: captured word from the last completed test.

Behaviour:
- Reset: state IDLE, counter 0, pattern/expect/result registers 0.
  - All outputs low/zero: scan_enable=0, scan_in=0, busy=0, done=0, pass=0, result_out=0.
  - Reset asserted mid-test returns to IDLE immediately, with no done pulse.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE. The counter is sized for max(CHAIN_LEN, CAPTURE_CYCLES).
- IDLE:
  - start=1 at a clock edge latches pattern_in/expect_in, clears pass and result_out, loads counter = CHAIN_LEN-1, and moves to SHIFT_IN.
  - Otherwise remains in IDLE.
- SHIFT_IN (CHAIN_LEN cycles):
  - scan_enable=1; scan_in = pattern shift register bit 0.
  - Shift register moves right one bit per cycle, so pattern bit 0 is sent first.
  - After the last edge the chain holds pattern_in exactly.
  - When counter=0, load counter = CAPTURE_CYCLES-1 and go to CAPTURE.
- CAPTURE (CAPTURE_CYCLES cycles):
  - scan_enable=0, scan_in=0; the chain loads its functional input each cycle.
  - When counter=0, load counter = CHAIN_LEN-1 and go to SHIFT_OUT.
- SHIFT_OUT (CHAIN_LEN cycles):
  - scan_enable=1, scan_in=0, so the chain refills with zeros.
  - Each edge shifts scan_out into result at the MSB (result <= {scan_out, result[MSB:1]}).
  - After CHAIN_LEN edges, result equals the captured word.
  - When counter=0, go to DONE.
- DONE (1 cycle):
  - scan_enable=0, done=1, result_out=result, pass=(result==expect).
  - Always returns to IDLE. start is ignored in this cycle.
- Latency: with start accepted at edge E0, done is high during cycle 2*CHAIN_LEN+CAPTURE_CYCLES+1 after E0 (cycle 18 with defaults). busy is high for exactly that many cycles.
- Outputs scan_enable, scan_in, busy and done are decoded from registered state/shift bits; there is no combinational path from inputs to outputs.
- start while busy is ignored and not queued.
- abort=1 in any non-IDLE state moves to IDLE at the next edge.
  - No done pulse; pass/result_out keep their cleared values.
  - abort in IDLE has no effect, and abort wins over a simultaneous start.
- pass/result_out hold until the next accepted start.

Test Plan:
- Defaults; bench feeds chain func_data_in=0x3C; start with pattern_in=0xA5, expect_in=0x3C -> chain func_data_out=0xA5 after 8 shift cycles; scan_enable low exactly 1 cycle; done pulse in cycle 18; result_out=0x3C, pass=1.
- Same stimulus with expect_in=0x3D -> done in cycle 18, result_out=0x3C, pass=0.
- Pulse start again at cycles 3 and 17 of a running test -> ignored; exactly one done; busy high 18 cycles; next start accepted only in IDLE.
- abort during SHIFT_OUT cycle 13 -> IDLE next edge; scan_enable=0, busy=0, no done; pass=0, result_out=0.
- rst_n low during CAPTURE -> all outputs zero immediately; after release, a new test with pattern 0xFF and func_data_in=0x00, expect 0x00 -> pass=1.
- CAPTURE_CYCLES=3, func_data_in=0x81, expect 0x81 -> scan_enable low 3 cycles; done in cycle 20; pass=1.
